// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - cs/ready request bus between requester and memory responder
interface bus_responder_if;
    logic        cs;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [31:0] ir;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output cs, sel, addr, wdata,
        input  rdata, ir, ready, err, busy
    );

    modport slave (
        input  cs, sel, addr, wdata,
        output rdata, ir, ready, err, busy
    );
endinterface

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - wait-stated RAM responder for read, write and 32-bit fetch requests
module bus_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    bus_responder_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    // The counter is loaded with WAIT_STATES-1 and WAIT exits on zero, giving exactly WAIT_STATES cycles.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT1,
        S_BEAT2,
        S_DONE,
        S_HOLD
    } state_t;

    state_t              state;
    logic [1:0]          op;
    logic [ADDR_W-1:0]   a;
    logic [15:0]         wd;
    logic [3:0]          wait_cnt;
    logic                second_beat;
    logic [15:0]         rdata_q;
    logic [31:0]         ir_q;
    logic                ready_q;
    logic                err_q;
    logic                busy_q;

    logic [15:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   a_next;
    logic                mem_we;

    // Second fetch word wraps at DEPTH-1 through natural ADDR_W-bit overflow.
    assign a_next = a + 1'b1;
    assign mem_we = (state == S_BEAT1) && (op == OP_WRITE);

    assign bus.rdata = rdata_q;
    assign bus.ir    = ir_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

    // RAM write port; contents deliberately survive reset, and a write racing reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[a] <= wd;
        end
    end

    // Request sequencer: accept, wait, one or two memory beats, single-cycle completion, then hold for cs low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= OP_READ;
            a           <= '0;
            wd          <= '0;
            wait_cnt    <= '0;
            second_beat <= 1'b0;
            rdata_q     <= '0;
            ir_q        <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cs) begin
                        op          <= bus.sel;
                        a           <= bus.addr[ADDR_W-1:0];
                        wd          <= bus.wdata;
                        busy_q      <= 1'b1;
                        second_beat <= 1'b0;
                        if (bus.sel == OP_RSVD) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else if (WAIT_STATES == 0) begin
                            state <= S_BEAT1;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= second_beat ? S_BEAT2 : S_BEAT1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_BEAT1: begin
                    case (op)
                        OP_READ: begin
                            rdata_q <= mem[a];
                            ready_q <= 1'b1;
                            state   <= S_DONE;
                        end
                        OP_WRITE: begin
                            ready_q <= 1'b1;
                            state   <= S_DONE;
                        end
                        default: begin
                            ir_q[31:16] <= mem[a];
                            second_beat <= 1'b1;
                            if (WAIT_STATES == 0) begin
                                state <= S_BEAT2;
                            end else begin
                                wait_cnt <= WAIT_INIT;
                                state    <= S_WAIT;
                            end
                        end
                    endcase
                end
                S_BEAT2: begin
                    ir_q[15:0] <= mem[a_next];
                    ready_q    <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.cs) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

    localparam int WS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bus_responder_if bus ();

    bus_responder #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_model [256];
    logic [15:0] m_rdata;
    logic [31:0] m_ir;

    int r_lat, r_pulses, r_both, r_busy_clear, r_busy_early, r_drop;
    bit r_err_seen, r_ready_seen, r_timeout;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          hold;
        bit          exp_err;
        int          exp_lat;
        logic [15:0] exp_rdata;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request; sel/addr/wdata are scrambled after acceptance and must be ignored.
    task automatic do_req(input logic [1:0] s, input logic [15:0] a, input logic [15:0] w, input int hold);
        bit released;
        bus.cs    = 1'b1;
        bus.sel   = s;
        bus.addr  = a;
        bus.wdata = w;
        @(posedge clk);
        #1;
        bus.sel   = 2'($urandom);
        bus.addr  = 16'($urandom);
        bus.wdata = 16'($urandom);
        released  = 1'b0;
        r_drop    = 0;
        if (hold == 0) begin
            bus.cs   = 1'b0;
            released = 1'b1;
        end
        r_lat = 0; r_pulses = 0; r_both = 0; r_busy_clear = 0; r_busy_early = 0;
        r_err_seen = 0; r_ready_seen = 0; r_timeout = 1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (bus.ready || bus.err) begin
                r_pulses++;
                if (r_lat == 0) r_lat = n;
            end
            if (bus.ready) r_ready_seen = 1;
            if (bus.err) r_err_seen = 1;
            if (bus.ready && bus.err) r_both++;
            if (!bus.busy) begin
                if (r_lat != 0 && released) begin
                    r_busy_clear = n;
                    r_timeout = 0;
                    break;
                end else begin
                    r_busy_early++;
                end
            end
            @(posedge clk);
            #1;
            if (!released && r_lat != 0 && n >= hold) begin
                bus.cs   = 1'b0;
                released = 1'b1;
                r_drop   = n;
            end
        end
    endtask

    task automatic check_resp(input string tag, input int exp_lat, input bit exp_err,
                              input logic [15:0] exp_rdata, input logic [31:0] exp_ir);
        int exp_clear;
        exp_clear = ((r_drop > exp_lat) ? r_drop : exp_lat) + 2;
        check({tag, ".timeout"}, r_timeout, 0);
        check({tag, ".latency"}, r_lat, exp_lat);
        check({tag, ".pulses"}, r_pulses, 1);
        check({tag, ".ready_and_err"}, r_both, 0);
        check({tag, ".err"}, r_err_seen, exp_err);
        check({tag, ".ready"}, r_ready_seen, !exp_err);
        check({tag, ".busy_early_low"}, r_busy_early, 0);
        check({tag, ".busy_clear"}, r_busy_clear, exp_clear);
        check({tag, ".rdata"}, bus.rdata, exp_rdata);
        check({tag, ".ir"}, bus.ir, exp_ir);
    endtask

    // Reference behaviour: plain word array, latency from the documented formulas.
    task automatic model_req(input logic [1:0] s, input logic [15:0] a, input logic [15:0] w,
                             output int lat, output bit is_err);
        logic [7:0] i;
        logic [7:0] j;
        i = a[7:0];
        j = i + 8'd1;
        is_err = 0;
        case (s)
            2'b00: begin m_rdata = mem_model[i]; lat = WS + 2; end
            2'b01: begin mem_model[i] = w; lat = WS + 2; end
            2'b10: begin m_ir = {mem_model[i], mem_model[j]}; lat = 2 * WS + 3; end
            default: begin is_err = 1; lat = 1; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          is_err, saw;
        logic [1:0]  s;
        logic [15:0] a, w;

        vecs[0]  = '{2'b01, 16'h0010, 16'hBEEF, 0,  0, 4, 16'h0000, 32'h0000_0000};
        vecs[1]  = '{2'b00, 16'h0010, 16'h0000, 0,  0, 4, 16'hBEEF, 32'h0000_0000};
        vecs[2]  = '{2'b01, 16'h00FF, 16'h1234, 3,  0, 4, 16'hBEEF, 32'h0000_0000};
        vecs[3]  = '{2'b01, 16'h0000, 16'h5678, 0,  0, 4, 16'hBEEF, 32'h0000_0000};
        vecs[4]  = '{2'b10, 16'h00FF, 16'h0000, 0,  0, 7, 16'hBEEF, 32'h1234_5678};
        vecs[5]  = '{2'b01, 16'h0103, 16'hA5A5, 0,  0, 4, 16'hBEEF, 32'h1234_5678};
        vecs[6]  = '{2'b00, 16'h0003, 16'h0000, 0,  0, 4, 16'hA5A5, 32'h1234_5678};
        vecs[7]  = '{2'b11, 16'h0010, 16'hFFFF, 2,  1, 1, 16'hA5A5, 32'h1234_5678};
        vecs[8]  = '{2'b01, 16'h0011, 16'h4321, 0,  0, 4, 16'hA5A5, 32'h1234_5678};
        vecs[9]  = '{2'b10, 16'h0010, 16'h0000, 1,  0, 7, 16'hA5A5, 32'hBEEF_4321};
        vecs[10] = '{2'b00, 16'h0010, 16'h0000, 10, 0, 4, 16'hBEEF, 32'hBEEF_4321};

        bus.cs = 1'b0; bus.sel = 2'b00; bus.addr = '0; bus.wdata = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ready", bus.ready, 0);
        check("reset.err", bus.err, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.rdata", bus.rdata, 0);
        check("reset.ir", bus.ir, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            do_req(vecs[k].sel, vecs[k].addr, vecs[k].wdata, vecs[k].hold);
            check_resp($sformatf("vec%0d", k), vecs[k].exp_lat, vecs[k].exp_err,
                       vecs[k].exp_rdata, vecs[k].exp_ir);
        end

        // Reset while a write sits in WAIT: nothing committed, outputs clear at once.
        do_req(2'b01, 16'h0020, 16'h1111, 0);
        check_resp("pre_reset_write", 4, 0, 16'hBEEF, 32'hBEEF_4321);
        bus.cs = 1'b1; bus.sel = 2'b01; bus.addr = 16'h0020; bus.wdata = 16'h0F0F;
        @(posedge clk);
        #1 bus.cs = 1'b0;
        @(negedge clk);
        check("rst_mid.busy_before", bus.busy, 1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid.busy", bus.busy, 0);
        check("rst_mid.ready", bus.ready, 0);
        check("rst_mid.rdata", bus.rdata, 0);
        check("rst_mid.ir", bus.ir, 0);
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ready || bus.err) saw = 1;
        end
        check("rst_mid.no_pulse", saw, 0);
        reset = 1'b0;
        do_req(2'b00, 16'h0020, 16'h0000, 0);
        check_resp("post_reset_read", 4, 0, 16'h1111, 32'h0000_0000);

        m_rdata = 16'h1111;
        m_ir    = 32'h0;

        // Fill every word through the bus so the model and RAM agree everywhere.
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            a = {8'($urandom), 8'(i)};
            model_req(2'b01, a, w, lat, is_err);
            do_req(2'b01, a, w, 0);
            check_resp($sformatf("fill%0d", i), lat, is_err, m_rdata, m_ir);
        end

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: s = 2'b00;
                3, 4, 5: s = 2'b01;
                6, 7, 8: s = 2'b10;
                default: s = 2'b11;
            endcase
            a = 16'($urandom);
            if ($urandom_range(0, 5) == 0) a[7:0] = 8'hFF;
            w = 16'($urandom);
            model_req(s, a, w, lat, is_err);
            do_req(s, a, w, int'($urandom_range(0, 6)));
            check_resp($sformatf("rand%0d", k), lat, is_err, m_rdata, m_ir);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the processor's chip-select/ready bus handshake; it services requests that the bus interface unit initiates.
- Each request is a data read, a data write or a 32-bit instruction fetch. All are completed against an internal word-addressed RAM after a programmable number of wait states.
- Completion is signalled with a one-cycle ready pulse, the same cs/ready convention the control unit uses towards its sub-units.

Parameters:
ADDR_W, 8, address bits actually decoded; DEPTH = 2**ADDR_W words of 16 bits
WAIT_STATES, 2, idle cycles inserted before each memory beat (0..15 legal)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cs  input  1  request select from requester, level-held until ready seen
sel  input  2  00 data read, 01 data write, 10 instruction fetch, 11 reserved
addr  input  16  word address; only addr[ADDR_W-1:0] decoded, upper bits ignored
wdata  input  16  write data, sampled at acceptance
rdata  output  16  read data for sel=00
ir  output  32  fetched instruction for sel=10
ready  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse instead of ready for sel=11
busy  output  1  high from acceptance until the request is fully retired

Behaviour:
- Reset (async, any state): state=IDLE; ready=0, err=0, busy=0, rdata=0, ir=0. RAM contents are not cleared and survive reset. A write in flight when reset asserts is not committed.
- States: IDLE, WAIT, BEAT1, BEAT2, DONE, HOLD.
- IDLE: on an edge with cs=1, latch sel, addr[ADDR_W-1:0] and wdata, and set busy=1. With sel=11 go to DONE with err flagged. Otherwise go to WAIT, or straight to BEAT1 if WAIT_STATES=0.
- WAIT: count WAIT_STATES cycles, then BEAT1.
- BEAT1:
  - read: rdata <= mem[a].
  - write: mem[a] <= wdata.
  - fetch: ir[31:16] <= mem[a]; then WAIT again (fresh count) and BEAT2.
  - read/write go to DONE.
- BEAT2 (fetch only): ir[15:0] <= mem[(a+1) mod DEPTH]; go to DONE. Wrap-around at DEPTH-1 is required.
- DONE: assert ready=1 (or err=1 for reserved) for exactly this cycle; go to HOLD.
- HOLD: wait for cs=0, then busy=0 and go to IDLE. A cs held high after ready never retriggers a second access.
- Latency, counted from the accepting edge to the cycle ready is high:
  - read/write: WAIT_STATES+2 cycles.
  - fetch: 2*WAIT_STATES+3 cycles.
  - reserved: 1 cycle.
- rdata and ir hold their last value until overwritten by a later read or fetch. They are stable and valid whenever ready=1.
- sel, addr and wdata changes after acceptance are ignored. cs deassertion before ready does not abort the request; it completes and pulses ready, then HOLD exits immediately.
- ready and err are never high together. Neither is ever high outside DONE.
- Minimum spacing between two accepted requests is 1 cycle with cs low (HOLD to IDLE to accept).

Test Plan:
- WAIT_STATES=2: write sel=01 addr=0x0010 wdata=0xBEEF, then read sel=00 addr=0x0010. Required: each ready pulse lands exactly 4 cycles after acceptance; rdata=0xBEEF.
- Fetch wrap: preload mem[0xFF]=0x1234 and mem[0x00]=0x5678; fetch sel=10 addr=0x00FF. Required: ir=0x12345678; ready arrives 7 cycles after acceptance.
- Aliasing: write 0xA5A5 to addr=0x0103, then read addr=0x0003. Required: rdata=0xA5A5.
- Reserved op: sel=11. Required: err=1 for one cycle the cycle after acceptance; ready stays 0; rdata and ir unchanged; busy returns to 0 after cs=0.
- cs held high for 10 cycles across a read. Required: exactly one ready pulse. The next access starts only after cs has been seen low.
- Reset during WAIT of a write of 0x0F0F to addr 0x20 (previous value 0x1111). Required: outputs go to 0 immediately on reset, no ready pulse, and a subsequent read of 0x20 returns 0x1111.
